mcr_nvram_upload: RTL and testbench
===================================

# mcr_nvram_upload

Responder for the HPS upload direction of the ioctl channel: serves NVRAM bytes to the HPS on `ioctl_din` with `ioctl_wait` flow control when the framework saves high scores. It sits between `hps_io` and the CPU-side NVRAM dual-port RAM's second port. It tracks CPU writes to NVRAM and requests a save when the OSD opens with unsaved data.

## Interface
- `NV_INDEX`, 8'd4: ioctl index that selects NVRAM.
- `ADDR_W`, 10: NVRAM address width in bytes, giving a size of 2^ADDR_W.
- `RD_LAT`, 1: NVRAM read latency in cycles, from `nvram_rd` to valid `nvram_q`. Range 1..3.
- `clk_sys` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `ioctl_upload` in 1: an upload is in progress.
- `ioctl_index` in 8: selected index.
- `ioctl_addr` in 25: byte address requested by the HPS.
- `ioctl_rd` in 1: one-cycle read request strobe.
- `ioctl_din` out 8: byte returned to the HPS.
- `ioctl_wait` out 1: tells the HPS to hold off. While it is high, `ioctl_din` is not valid.
- `nvram_addr` out ADDR_W: RAM read address.
- `nvram_rd` out 1: one-cycle RAM read enable.
- `nvram_q` in 8: RAM read data.
- `nvram_cpu_wr` in 1: CPU write strobe to NVRAM.
- `osd_status` in 1: OSD open level.
- `dirty` out 1: NVRAM has been modified since the last completed upload.
- `upload_req` out 1: one-cycle save request to `hps_io`.

## Operation
- Reset values, applied asynchronously when `reset_n`=0:
  - `ioctl_din`=8'h00, `ioctl_wait`=0, `nvram_rd`=0, `nvram_addr`=0, `dirty`=0, `upload_req`=0.
  - State is IDLE and the edge-detect registers are 0.
- A request is accepted only when `ioctl_rd`=1 and `ioctl_upload`=1 and `ioctl_index`==NV_INDEX, with the FSM in IDLE.
- Requests that do not meet those conditions are ignored and `ioctl_din` holds its value. This includes any `ioctl_rd` arriving while the FSM is in FETCH.
- FSM has states IDLE, FETCH and OOR.
  - IDLE → FETCH on an accepted request with `ioctl_addr` < 2^ADDR_W.
    - On entry: `nvram_addr`=`ioctl_addr[ADDR_W-1:0]`, `nvram_rd`=1 for one cycle, `ioctl_wait`=1.
    - A latency counter loads RD_LAT.
  - FETCH: the counter decrements each cycle. When it reaches 0, `ioctl_din`←`nvram_q`, `ioctl_wait`←0, and the FSM returns to IDLE.
  - IDLE → OOR on an accepted request with `ioctl_addr` ≥ 2^ADDR_W.
    - `ioctl_wait`=1 for exactly one cycle, with no RAM access.
    - Then `ioctl_din`←8'hFF and the FSM returns to IDLE.
  - If `ioctl_upload` falls while in FETCH or OOR, the read completes normally. The HPS ignores the result.
- Dirty tracking:
  - `nvram_cpu_wr`=1 sets `dirty`.
  - `dirty` clears on the falling edge of `ioctl_upload` while `ioctl_index`==NV_INDEX.
  - If a CPU write coincides with that falling edge, `dirty` stays 1, so the set has priority.
  - A CPU write during an upload sets `dirty`, and it remains set after the upload ends.
- Save request: on the rising edge of `osd_status` while `dirty`=1 and `ioctl_upload`=0, `upload_req` pulses high for one cycle.
  - Holding the OSD open produces no repeated pulses.

## Timing
- Request sampled at edge E0 (in-range address):
  - From E0: `ioctl_wait`=1, `nvram_rd`=1 and `nvram_addr` are valid. `nvram_rd` drops after E1.
  - At edge E(RD_LAT+1): `ioctl_din` updates and `ioctl_wait`=0.
  - `ioctl_wait` is high for exactly RD_LAT+1 cycles.
- Out-of-range address: `ioctl_wait` is high for exactly 1 cycle and `ioctl_din`=8'hFF from E1.
- Back-to-back: a new request is accepted on the first cycle that `ioctl_wait`=0. Throughput is one byte per RD_LAT+2 cycles.
- `upload_req` is asserted in the cycle after the sampled `osd_status` 0→1 edge.
- All outputs are registered, with no combinational path from inputs.

## Structure
- Shared package `mcr_pkg`:
  - Constant `NVRAM_IOCTL_INDEX`=8'd4.
  - Typedef `nv_state_t` as an enum of IDLE, FETCH and OOR.
- No sub-module is required. Edge detection for `ioctl_upload` and `osd_status` stays inline, with one register each.

## Test plan
- In-range read, RD_LAT=1: RAM[0x005]=8'h5A, then an `ioctl_rd` pulse at addr 5 with index 4 → `nvram_rd` fires one cycle with addr 5, `ioctl_wait` is high 2 cycles, and `ioctl_din`=8'h5A.
- Out of range: addr 0x400 with ADDR_W=10 → no `nvram_rd`, `ioctl_wait` is high 1 cycle, `ioctl_din`=8'hFF.
- Filtering:
  - `ioctl_rd` with index 0 → no response and `ioctl_din` unchanged.
  - A second `ioctl_rd` during FETCH → ignored, and only one `nvram_rd` is seen.
- Dirty and save request: CPU write, then `osd_status` 0→1 → one `upload_req` pulse.
  - Second OSD open with no new write but no upload yet → another pulse.
  - After a full upload completes, OSD open → no pulse.
- Coincident events:
  - CPU write on the same cycle as the `ioctl_upload` falling edge → `dirty`=1 afterwards.
  - CPU write mid-upload → `dirty`=1 after the upload ends.
- Reset mid-FETCH, RD_LAT=3: drop `reset_n` → all outputs go to reset values immediately.
  - After release, a new request completes with `ioctl_wait` high exactly 4 cycles.

Source files
------------

// File: rtl/mcr_nvram_upload_pkg.sv
// Shared MCR definitions: ioctl index for NVRAM, upload FSM states and an
// address range helper used by the NVRAM upload responder.
package mcr_pkg;

  localparam logic [7:0] NVRAM_IOCTL_INDEX = 8'd4;
  localparam int         IOCTL_ADDR_W      = 25;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    OOR
  } nv_state_t;

  // True when a byte address fits inside a RAM of 2^aw bytes.
  function automatic logic addr_in_range(input logic [IOCTL_ADDR_W-1:0] addr,
                                         input int unsigned aw);
    return (addr >> aw) == '0;
  endfunction

endpackage

// File: rtl/mcr_nvram_upload_if.sv
// ioctl upload channel between hps_io (master) and an upload responder (slave).
interface mcr_nvram_upload_if;

  logic                            ioctl_upload;
  logic [7:0]                      ioctl_index;
  logic [mcr_pkg::IOCTL_ADDR_W-1:0] ioctl_addr;
  logic                            ioctl_rd;
  logic [7:0]                      ioctl_din;
  logic                            ioctl_wait;

  modport master (
    output ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    input  ioctl_din, ioctl_wait
  );

  modport slave (
    input  ioctl_upload, ioctl_index, ioctl_addr, ioctl_rd,
    output ioctl_din, ioctl_wait
  );

endinterface

// File: rtl/mcr_nvram_upload.sv
// Serves NVRAM bytes to the HPS over the ioctl upload channel, tracks CPU
// writes to NVRAM and requests a save when the OSD opens with unsaved data.
module mcr_nvram_upload
  import mcr_pkg::*;
#(
  parameter logic [7:0] NV_INDEX = NVRAM_IOCTL_INDEX,
  parameter int         ADDR_W   = 10,
  parameter int         RD_LAT   = 1
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  mcr_nvram_upload_if.slave ioctl,
  output logic [ADDR_W-1:0] nvram_addr,
  output logic              nvram_rd,
  input  logic [7:0]        nvram_q,
  input  logic              nvram_cpu_wr,
  input  logic              osd_status,
  output logic              dirty,
  output logic              upload_req
);

  localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

  nv_state_t         state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [7:0]        din_q, din_d;
  logic              wait_q, wait_d;
  logic              rd_q, rd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic req_ok;
  logic nv_sel;

  assign nv_sel = (ioctl.ioctl_index == NV_INDEX);
  assign req_ok = ioctl.ioctl_rd & ioctl.ioctl_upload & nv_sel;

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    din_d   = din_q;
    wait_d  = wait_q;
    rd_d    = 1'b0;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (req_ok) begin
          wait_d = 1'b1;
          if (addr_in_range(ioctl.ioctl_addr, ADDR_W)) begin
            state_d = FETCH;
            addr_d  = ioctl.ioctl_addr[ADDR_W-1:0];
            rd_d    = 1'b1;
            lat_d   = LAT_INIT;
          end else begin
            state_d = OOR;
          end
        end
      end

      // Counter runs RD_LAT..0, so data is captured RD_LAT+1 edges after the
      // request, one edge after the RAM output becomes valid.
      FETCH: begin
        if (lat_q == 2'd0) begin
          din_d   = nvram_q;
          wait_d  = 1'b0;
          state_d = IDLE;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end

      OOR: begin
        din_d   = 8'hFF;
        wait_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        wait_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lat_q   <= '0;
      din_q   <= 8'h00;
      wait_q  <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      din_q   <= din_d;
      wait_q  <= wait_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
    end
  end

  assign ioctl.ioctl_din  = din_q;
  assign ioctl.ioctl_wait = wait_q;
  assign nvram_addr       = addr_q;
  assign nvram_rd         = rd_q;

  logic upload_q;
  logic osd_q;
  logic wr_seen_q;
  logic dirty_q;
  logic req_q;
  logic upload_fall;

  assign upload_fall = upload_q & ~ioctl.ioctl_upload;

  // A write seen during an NVRAM upload may postdate the byte the HPS already
  // fetched, so the end of that upload must not clear dirty.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      upload_q  <= 1'b0;
      osd_q     <= 1'b0;
      wr_seen_q <= 1'b0;
      dirty_q   <= 1'b0;
      req_q     <= 1'b0;
    end else begin
      upload_q <= ioctl.ioctl_upload;
      osd_q    <= osd_status;
      req_q    <= osd_status & ~osd_q & dirty_q & ~ioctl.ioctl_upload;

      if (upload_fall) begin
        wr_seen_q <= 1'b0;
      end else if (nvram_cpu_wr && ioctl.ioctl_upload && nv_sel) begin
        wr_seen_q <= 1'b1;
      end

      if (nvram_cpu_wr) begin
        dirty_q <= 1'b1;
      end else if (upload_fall && nv_sel) begin
        dirty_q <= wr_seen_q;
      end
    end
  end

  assign dirty      = dirty_q;
  assign upload_req = req_q;

endmodule

// File: tb/tb_mcr_nvram_upload.sv
// Bench for mcr_nvram_upload: two instances (RD_LAT 1 and 3) against a RAM
// model and an event-level reference for read results and dirty tracking.
module tb_mcr_nvram_upload;
  import mcr_pkg::*;

  localparam int ADDR_W   = 10;
  localparam int MEM_SIZE = 1 << ADDR_W;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk_sys = ~clk_sys;

  mcr_nvram_upload_if if1 ();
  mcr_nvram_upload_if if3 ();

  logic [ADDR_W-1:0] nv_addr1, nv_addr3;
  logic              nv_rd1, nv_rd3;
  logic [7:0]        nv_q1, nv_q3;
  logic              cpu_wr1, cpu_wr3, osd1, osd3;
  logic              dirty1, dirty3, req1, req3;

  mcr_nvram_upload #(.NV_INDEX(8'd4), .ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(if1.slave),
    .nvram_addr(nv_addr1), .nvram_rd(nv_rd1), .nvram_q(nv_q1),
    .nvram_cpu_wr(cpu_wr1), .osd_status(osd1), .dirty(dirty1), .upload_req(req1)
  );

  mcr_nvram_upload #(.NV_INDEX(8'd4), .ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl(if3.slave),
    .nvram_addr(nv_addr3), .nvram_rd(nv_rd3), .nvram_q(nv_q3),
    .nvram_cpu_wr(cpu_wr3), .osd_status(osd3), .dirty(dirty3), .upload_req(req3)
  );

  // RAM models: shared contents, latency 1 and latency 3 read ports.
  logic [7:0] mem [MEM_SIZE];
  logic [7:0] s0, s1;

  always @(posedge clk_sys) begin
    if (nv_rd1) nv_q1 <= mem[nv_addr1];
  end

  always @(posedge clk_sys) begin
    if (nv_rd3) s0 <= mem[nv_addr3];
    s1    <= s0;
    nv_q3 <= s1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_din1, exp_din3;
  logic       exp_dirty;

  function automatic logic get_wait(input int sel);
    return (sel == 1) ? if1.ioctl_wait : if3.ioctl_wait;
  endfunction

  function automatic logic get_rd(input int sel);
    return (sel == 1) ? nv_rd1 : nv_rd3;
  endfunction

  function automatic logic [ADDR_W-1:0] get_addr(input int sel);
    return (sel == 1) ? nv_addr1 : nv_addr3;
  endfunction

  function automatic logic [7:0] get_din(input int sel);
    return (sel == 1) ? if1.ioctl_din : if3.ioctl_din;
  endfunction

  task automatic drive(input int sel, input logic rd, input logic [24:0] addr,
                       input logic [7:0] idx, input logic up);
    if (sel == 1) begin
      if1.ioctl_rd = rd; if1.ioctl_addr = addr; if1.ioctl_index = idx; if1.ioctl_upload = up;
    end else begin
      if3.ioctl_rd = rd; if3.ioctl_addr = addr; if3.ioctl_index = idx; if3.ioctl_upload = up;
    end
  endtask

  task automatic set_rd(input int sel, input logic v);
    if (sel == 1) if1.ioctl_rd = v;
    else          if3.ioctl_rd = v;
  endtask

  // Reference: what one ioctl_rd pulse should produce, from the protocol rules.
  function automatic void model_txn(input int sel, input logic [24:0] addr,
                                    input logic [7:0] idx, input logic up,
                                    input logic [7:0] prev, output int ehi,
                                    output int erd, output logic [7:0] edin);
    int lat;
    lat = (sel == 1) ? 1 : 3;
    if (!(up && idx == NVRAM_IOCTL_INDEX)) begin
      ehi = 0; erd = 0; edin = prev;
    end else if (addr < MEM_SIZE) begin
      ehi = lat + 1; erd = 1; edin = mem[addr[ADDR_W-1:0]];
    end else begin
      ehi = 1; erd = 0; edin = 8'hFF;
    end
  endfunction

  // Issue one read pulse and observe an 8-cycle window after the sampling edge.
  task automatic read_txn(input int sel, input logic [24:0] addr, input logic [7:0] idx,
                          input logic up, output int hi, output int rds,
                          output logic [ADDR_W-1:0] ra, output logic [7:0] din);
    @(negedge clk_sys);
    drive(sel, 1'b1, addr, idx, up);
    hi = 0; rds = 0; ra = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_sys);
      if (i == 0) set_rd(sel, 1'b0);
      if (get_wait(sel)) hi++;
      if (get_rd(sel)) begin
        rds++;
        ra = get_addr(sel);
      end
    end
    din = get_din(sel);
  endtask

  task automatic osd_open(input logic up, output int pulses);
    @(negedge clk_sys);
    if1.ioctl_upload = up;
    if1.ioctl_index  = 8'd4;
    osd1   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      if (req1) pulses++;
    end
    osd1 = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic upload_session(input bit wr_mid, input bit wr_fall);
    int hi, rds;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din;
    logic [24:0] a;
    for (int k = 0; k < 2; k++) begin
      a = 25'($urandom_range(0, MEM_SIZE - 1));
      read_txn(1, a, 8'd4, 1'b1, hi, rds, ra, din);
      n_checks++;
      if (din !== mem[a[ADDR_W-1:0]]) begin
        n_fail++;
        $display("FAIL session_read addr=%0h got=%h want=%h", a, din, mem[a[ADDR_W-1:0]]);
      end
      exp_din1 = mem[a[ADDR_W-1:0]];
      if (wr_mid && k == 0) begin
        @(negedge clk_sys); cpu_wr1 = 1'b1;
        @(negedge clk_sys); cpu_wr1 = 1'b0;
      end
    end
    @(negedge clk_sys);
    if1.ioctl_upload = 1'b0;
    cpu_wr1 = wr_fall;
    @(negedge clk_sys);
    cpu_wr1 = 1'b0;
    @(negedge clk_sys);
    exp_dirty = wr_mid | wr_fall;
  endtask

  task automatic test_reset();
    #1 reset_n = 1'b0;
    #2;
    n_checks++;
    if (if1.ioctl_din !== 8'h00 || if1.ioctl_wait !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ioctl1 din=%h wait=%b want 00/0", if1.ioctl_din, if1.ioctl_wait);
    end
    n_checks++;
    if (nv_rd1 !== 1'b0 || nv_addr1 !== '0) begin
      n_fail++;
      $display("FAIL reset_nvram1 rd=%b addr=%h want 0/000", nv_rd1, nv_addr1);
    end
    n_checks++;
    if (dirty1 !== 1'b0 || req1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dirty1 dirty=%b req=%b want 0/0", dirty1, req1);
    end
    n_checks++;
    if ({if3.ioctl_din, if3.ioctl_wait, nv_rd3, nv_addr3, dirty3, req3} !== '0) begin
      n_fail++;
      $display("FAIL reset_dut3 din=%h wait=%b rd=%b addr=%h dirty=%b req=%b want all 0",
               if3.ioctl_din, if3.ioctl_wait, nv_rd3, nv_addr3, dirty3, req3);
    end
    exp_din1 = 8'h00; exp_din3 = 8'h00; exp_dirty = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

  task automatic test_in_range();
    int hi, rds;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din;
    mem[5] = 8'h5A;
    read_txn(1, 25'd5, 8'd4, 1'b1, hi, rds, ra, din);
    n_checks++;
    if (rds !== 1 || ra !== 10'd5) begin
      n_fail++;
      $display("FAIL in_range_rd pulses=%0d addr=%h want 1/005", rds, ra);
    end
    n_checks++;
    if (hi !== 2) begin
      n_fail++;
      $display("FAIL in_range_wait cycles=%0d want 2", hi);
    end
    n_checks++;
    if (din !== 8'h5A) begin
      n_fail++;
      $display("FAIL in_range_din got=%h want 5a", din);
    end
    exp_din1 = 8'h5A;
  endtask

  task automatic test_out_of_range();
    int hi, rds;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din;
    for (int s = 1; s <= 3; s += 2) begin
      read_txn(s, 25'h400, 8'd4, 1'b1, hi, rds, ra, din);
      n_checks++;
      if (rds !== 0 || hi !== 1 || din !== 8'hFF) begin
        n_fail++;
        $display("FAIL oor_lat%0d rd=%0d wait=%0d din=%h want 0/1/ff", s, rds, hi, din);
      end
    end
    exp_din1 = 8'hFF; exp_din3 = 8'hFF;
  endtask

  task automatic test_filtering();
    int hi, rds;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din;
    read_txn(1, 25'd5, 8'd0, 1'b1, hi, rds, ra, din);
    n_checks++;
    if (hi !== 0 || rds !== 0 || din !== exp_din1) begin
      n_fail++;
      $display("FAIL filter_index wait=%0d rd=%0d din=%h want 0/0/%h", hi, rds, din, exp_din1);
    end
    read_txn(1, 25'd5, 8'd4, 1'b0, hi, rds, ra, din);
    n_checks++;
    if (hi !== 0 || rds !== 0 || din !== exp_din1) begin
      n_fail++;
      $display("FAIL filter_noupload wait=%0d rd=%0d din=%h want 0/0/%h", hi, rds, din, exp_din1);
    end

    mem[10'h010] = 8'h11;
    mem[10'h020] = 8'h22;
    @(negedge clk_sys);
    drive(3, 1'b1, 25'h010, 8'd4, 1'b1);
    hi = 0; rds = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_sys);
      if (i == 0) set_rd(3, 1'b0);
      if (i == 1) drive(3, 1'b1, 25'h020, 8'd4, 1'b1);
      if (i == 2) set_rd(3, 1'b0);
      if (get_wait(3)) hi++;
      if (get_rd(3)) rds++;
    end
    n_checks++;
    if (rds !== 1 || hi !== 4) begin
      n_fail++;
      $display("FAIL rd_during_fetch pulses=%0d wait=%0d want 1/4", rds, hi);
    end
    n_checks++;
    if (if3.ioctl_din !== 8'h11) begin
      n_fail++;
      $display("FAIL rd_during_fetch_din got=%h want 11", if3.ioctl_din);
    end
    exp_din3 = 8'h11;
  endtask

  task automatic test_back_to_back(input int sel);
    int lat, total, cyc, hi;
    logic [24:0] a;
    lat = (sel == 1) ? 1 : 3;
    total = 0;
    @(negedge clk_sys);
    for (int k = 0; k < 4; k++) begin
      a = 25'($urandom_range(0, MEM_SIZE - 1));
      drive(sel, 1'b1, a, 8'd4, 1'b1);
      @(negedge clk_sys);
      set_rd(sel, 1'b0);
      cyc = 1; hi = 0;
      while (get_wait(sel) && cyc < 12) begin
        hi++;
        @(negedge clk_sys);
        cyc++;
      end
      total += cyc;
      n_checks++;
      if (hi !== lat + 1 || get_din(sel) !== mem[a[ADDR_W-1:0]]) begin
        n_fail++;
        $display("FAIL b2b_lat%0d req%0d wait=%0d din=%h want %0d/%h",
                 lat, k, hi, get_din(sel), lat + 1, mem[a[ADDR_W-1:0]]);
      end
      if (sel == 1) exp_din1 = mem[a[ADDR_W-1:0]];
      else          exp_din3 = mem[a[ADDR_W-1:0]];
    end
    n_checks++;
    if (total !== 4 * (lat + 2)) begin
      n_fail++;
      $display("FAIL b2b_lat%0d_throughput cycles=%0d want %0d", lat, total, 4 * (lat + 2));
    end
  endtask

  task automatic test_random_reads();
    int sel, hi, rds, ehi, erd;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din, edin, idx;
    logic [24:0] a;
    logic up;
    for (int n = 0; n < 24; n++) begin
      sel = ($urandom_range(0, 1) == 0) ? 1 : 3;
      a   = 25'($urandom_range(0, 1279));
      idx = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 7)) : 8'd4;
      up  = ($urandom_range(0, 4) != 0);
      model_txn(sel, a, idx, up, (sel == 1) ? exp_din1 : exp_din3, ehi, erd, edin);
      read_txn(sel, a, idx, up, hi, rds, ra, din);
      n_checks++;
      if (hi !== ehi || rds !== erd || din !== edin ||
          (erd == 1 && ra !== a[ADDR_W-1:0])) begin
        n_fail++;
        $display("FAIL random[%0d] lat%0d addr=%h idx=%0d up=%b wait=%0d rd=%0d ra=%h din=%h want %0d/%0d/%h",
                 n, sel, a, idx, up, hi, rds, ra, din, ehi, erd, edin);
      end
      if (sel == 1) exp_din1 = edin;
      else          exp_din3 = edin;
    end
  endtask

  task automatic test_dirty();
    int pulses, want;
    upload_session(1'b0, 1'b0);
    n_checks++;
    if (dirty1 !== exp_dirty) begin
      n_fail++;
      $display("FAIL dirty_after_clean_upload got=%b want %b", dirty1, exp_dirty);
    end

    @(negedge clk_sys); cpu_wr1 = 1'b1;
    @(negedge clk_sys); cpu_wr1 = 1'b0;
    exp_dirty = 1'b1;
    @(negedge clk_sys);
    n_checks++;
    if (dirty1 !== exp_dirty) begin
      n_fail++;
      $display("FAIL dirty_after_write got=%b want %b", dirty1, exp_dirty);
    end

    for (int r = 0; r < 2; r++) begin
      want = exp_dirty ? 1 : 0;
      osd_open(1'b0, pulses);
      n_checks++;
      if (pulses !== want) begin
        n_fail++;
        $display("FAIL osd_open%0d pulses=%0d want %0d", r, pulses, want);
      end
    end

    upload_session(1'b0, 1'b0);
    n_checks++;
    if (dirty1 !== exp_dirty) begin
      n_fail++;
      $display("FAIL dirty_after_save got=%b want %b", dirty1, exp_dirty);
    end
    want = exp_dirty ? 1 : 0;
    osd_open(1'b0, pulses);
    n_checks++;
    if (pulses !== want) begin
      n_fail++;
      $display("FAIL osd_after_save pulses=%0d want %0d", pulses, want);
    end

    upload_session(1'b0, 1'b1);
    n_checks++;
    if (dirty1 !== exp_dirty) begin
      n_fail++;
      $display("FAIL dirty_write_at_fall got=%b want %b", dirty1, exp_dirty);
    end

    upload_session(1'b0, 1'b0);
    upload_session(1'b1, 1'b0);
    n_checks++;
    if (dirty1 !== exp_dirty) begin
      n_fail++;
      $display("FAIL dirty_write_mid_upload got=%b want %b", dirty1, exp_dirty);
    end

    want = (exp_dirty && 1'b0 == 1'b0) ? 0 : 0;
    osd_open(1'b1, pulses);
    n_checks++;
    if (pulses !== want) begin
      n_fail++;
      $display("FAIL osd_during_upload pulses=%0d want %0d", pulses, want);
    end
    @(negedge clk_sys);
    if1.ioctl_upload = 1'b0;
    @(negedge clk_sys);
    exp_dirty = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    int hi, rds;
    logic [ADDR_W-1:0] ra;
    logic [7:0] din;
    mem[10'h123] = 8'hA5;
    mem[10'h2C3] = 8'h3C;
    read_txn(3, 25'h123, 8'd4, 1'b1, hi, rds, ra, din);
    n_checks++;
    if (din !== 8'hA5) begin
      n_fail++;
      $display("FAIL pre_reset_read got=%h want a5", din);
    end
    @(negedge clk_sys); cpu_wr1 = 1'b1;
    @(negedge clk_sys); cpu_wr1 = 1'b0;

    @(negedge clk_sys);
    drive(3, 1'b1, 25'h2C3, 8'd4, 1'b1);
    @(negedge clk_sys);
    set_rd(3, 1'b0);
    n_checks++;
    if (if3.ioctl_wait !== 1'b1 || dirty1 !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_state wait=%b dirty=%b want 1/1", if3.ioctl_wait, dirty1);
    end
    @(posedge clk_sys);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({if3.ioctl_din, if3.ioctl_wait, nv_rd3, nv_addr3} !== '0 ||
        dirty1 !== 1'b0 || req1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_fetch din=%h wait=%b rd=%b addr=%h dirty=%b req=%b want all 0",
               if3.ioctl_din, if3.ioctl_wait, nv_rd3, nv_addr3, dirty1, req1);
    end
    @(negedge clk_sys);
    reset_n = 1'b1;
    exp_din1 = 8'h00; exp_din3 = 8'h00; exp_dirty = 1'b0;

    read_txn(3, 25'h2C3, 8'd4, 1'b1, hi, rds, ra, din);
    n_checks++;
    if (hi !== 4 || rds !== 1 || din !== 8'h3C) begin
      n_fail++;
      $display("FAIL after_reset_read wait=%0d rd=%0d din=%h want 4/1/3c", hi, rds, din);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));
    cpu_wr1 = 1'b0; cpu_wr3 = 1'b0; osd1 = 1'b0; osd3 = 1'b0;
    drive(1, 1'b0, '0, 8'd0, 1'b0);
    drive(3, 1'b0, '0, 8'd0, 1'b0);

    test_reset();
    test_in_range();
    test_out_of_range();
    test_filtering();
    test_back_to_back(1);
    test_back_to_back(3);
    test_random_reads();
    test_dirty();
    test_reset_mid_fetch();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
